// File: rtl/accel_dispatch.sv
// accel_dispatch: captures hash/encrypt/decrypt job requests from the CPU,
// arbitrates them round-robin (H, E, D) and issues them one at a time to the
// shared crypto engine, returning a one-cycle *_done pulse per finished job.
// Op encoding everywhere: 0 = hash, 1 = encrypt, 2 = decrypt.
// Optional build macro ACCEL_TIMEOUT_EN adds the TIMEOUT parameter, an engine
// watchdog and the sticky timeout_err output.
//
// Engine handshake: eng_start is asserted only while eng_ready is high, and a
// job is considered accepted in exactly the cycle eng_start=1; eng_op and
// eng_index are meaningful only in that cycle (driven to 0 otherwise).
// eng_finish is honoured only while a job is in flight (WAIT state).
module accel_dispatch #(
    parameter int IDX_W   = 11
`ifdef ACCEL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             H_int,
    input  logic             E_int,
    input  logic             D_int,
    input  logic [IDX_W-1:0] index,
    output logic             H_done,
    output logic             E_done,
    output logic             D_done,
    input  logic             eng_ready,
    output logic             eng_start,
    output logic [1:0]       eng_op,
    output logic [IDX_W-1:0] eng_index,
    input  logic             eng_finish,
    output logic             busy,
    output logic [2:0]       ovf
`ifdef ACCEL_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       req;
    logic [2:0]       req_q;
    logic [2:0]       rise;
    logic [2:0]       pending;
    logic [2:0]       clr;
    logic [IDX_W-1:0] idx [3];
    logic [1:0]       cur_op;
    logic [1:0]       last_grant;
    logic [1:0]       first;
    logic [1:0]       second;
    logic [1:0]       third;
    logic             grant_vld;
    logic [1:0]       grant_op;
    logic             wd_expire;

    assign req  = {D_int, E_int, H_int};
    assign rise = req & ~req_q;
    // pending bit of the op being handed to the engine this cycle
    assign clr  = {3{eng_start}} & (3'b001 << cur_op);

    // Request capture: edge-detect, store index, flag overflow on a busy slot
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            ovf     <= '0;
            for (int k = 0; k < 3; k++) idx[k] <= '0;
        end else begin
            req_q <= req;
            for (int k = 0; k < 3; k++) begin
                if (rise[k]) begin
                    // a new request in the issue cycle replaces the one leaving
                    if (pending[k] && !clr[k]) begin
                        ovf[k] <= 1'b1;
                    end else begin
                        pending[k] <= 1'b1;
                        idx[k]     <= index;
                    end
                end else if (clr[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search order starting after the last granted op
    always_comb begin
        first     = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        second    = (first == 2'd2) ? 2'd0 : first + 2'd1;
        third     = (second == 2'd2) ? 2'd0 : second + 2'd1;
        grant_vld = |pending;
        grant_op  = third;
        if (pending[first])       grant_op = first;
        else if (pending[second]) grant_op = second;
    end

`ifdef ACCEL_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wd_cnt;

    assign wd_expire = (state == WAIT) && (wd_cnt == CW'(TIMEOUT - 1));

    // Watchdog: counts WAIT cycles, flags a job the engine never finished
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT) wd_cnt <= '0;
            else               wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire && !eng_finish) timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // FSM state register plus grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_op     <= 2'd0;
            last_grant <= 2'd2;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                cur_op     <= grant_op;
                last_grant <= grant_op;
            end
        end
    end

    // FSM next state and engine/CPU outputs
    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_op    = 2'd0;
        eng_index = '0;
        H_done    = 1'b0;
        E_done    = 1'b0;
        D_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (eng_ready) begin
                    eng_start = 1'b1;
                    eng_op    = cur_op;
                    unique case (cur_op)
                        2'd1:    eng_index = idx[1];
                        2'd2:    eng_index = idx[2];
                        default: eng_index = idx[0];
                    endcase
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (eng_finish || wd_expire) state_nxt = DONE;
            end
            DONE: begin
                H_done    = (cur_op == 2'd0);
                E_done    = (cur_op == 2'd1);
                D_done    = (cur_op == 2'd2);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_accel_dispatch.sv
// Directed bench for accel_dispatch: a scoreboard queue holds the expected
// engine starts {op,index} and done ops; a negedge monitor pops and compares.
// Define ACCEL_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=16.
module tb_accel_dispatch;
  localparam int IDX_W = 11;
  localparam int W = 2 + IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic H_int = 1'b0, E_int = 1'b0, D_int = 1'b0;
  logic [IDX_W-1:0] index = '0;
  logic H_done, E_done, D_done;
  logic eng_ready = 1'b0;
  logic eng_start;
  logic [1:0] eng_op;
  logic [IDX_W-1:0] eng_index;
  logic eng_finish;
  logic busy;
  logic [2:0] ovf;
`ifdef ACCEL_TIMEOUT_EN
  logic timeout_err;
`endif

  logic man_fin = 1'b0;
  logic auto_fin = 1'b0;
  logic auto_eng = 1'b0;
  int fin_delay = 5;
  int fin_cnt = 0;
  assign eng_finish = man_fin | auto_fin;

  logic [W-1:0] exp_q[$];
  logic [1:0] exp_done_q[$];
  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int done_cnt = 0;

`ifdef ACCEL_TIMEOUT_EN
  accel_dispatch #(.IDX_W(IDX_W), .TIMEOUT(16)) dut (
`else
  accel_dispatch #(.IDX_W(IDX_W)) dut (
`endif
    .clk(clk), .rst(rst),
    .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index),
    .H_done(H_done), .E_done(E_done), .D_done(D_done),
    .eng_ready(eng_ready), .eng_start(eng_start), .eng_op(eng_op),
    .eng_index(eng_index), .eng_finish(eng_finish),
    .busy(busy), .ovf(ovf)
`ifdef ACCEL_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    H_int = 1'b0; E_int = 1'b0; D_int = 1'b0; index = '0;
    eng_ready = 1'b0; man_fin = 1'b0; auto_eng = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_job(input logic [1:0] op, input logic [IDX_W-1:0] ix);
    exp_q.push_back({op, ix});
    exp_done_q.push_back(op);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, (done_cnt >= target), 1);
  endtask

  // engine model: finishes fin_delay cycles after an accepted start
  initial forever begin
    @(negedge clk);
    auto_fin = 1'b0;
    if (rst) fin_cnt = 0;
    else begin
      if (fin_cnt == 1) auto_fin = 1'b1;
      if (fin_cnt > 0) fin_cnt--;
      if (auto_eng && eng_start) fin_cnt = fin_delay;
    end
  end

  // scoreboard monitor
  initial forever begin
    logic [W-1:0] e;
    logic [1:0] d;
    logic [2:0] dv;
    @(negedge clk);
    if (eng_start) begin
      start_cnt++;
      check("start_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("start_op_index", {eng_op, eng_index}, e);
      end
    end
    dv = {D_done, E_done, H_done};
    if (dv != 3'b000) begin
      done_cnt++;
      check("done_onehot", $onehot(dv), 1);
      check("done_expected", (exp_done_q.size() > 0), 1);
      if (exp_done_q.size() > 0) begin
        d = exp_done_q.pop_front();
        check("done_op", dv, 3'b001 << d);
      end
    end
  end

  initial begin
    int base_s;
    int base_d;

    // reset state
    rst = 1'b1;
    tick();
    check("rst_outputs", {H_done, E_done, D_done, eng_start, eng_op, eng_index}, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);

    // test 1: single hash job with fixed timing
    do_reset();
    eng_ready = 1'b1;
    H_int = 1'b1; index = 11'h155;
    push_job(2'd0, 11'h155);
    tick();
    H_int = 1'b0;
    check("t1_busy_pending", busy, 1);
    check("t1_no_early_start", eng_start, 0);
    tick();
    check("t1_start", eng_start, 1);
    check("t1_op", eng_op, 0);
    check("t1_index", eng_index, 11'h155);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t1_wait_no_done", {H_done, eng_start}, 0);
    end
    tick();
    man_fin = 1'b1;
    check("t1_fin_cycle_no_done", H_done, 0);
    tick();
    man_fin = 1'b0;
    check("t1_h_done", {D_done, E_done, H_done}, 3'b001);
    check("t1_busy_in_done", busy, 1);
    tick();
    check("t1_done_one_cycle", H_done, 0);
    check("t1_busy_low", busy, 0);

    // test 2: round robin of three simultaneous requests
    do_reset();
    base_s = start_cnt; base_d = done_cnt;
    eng_ready = 1'b1; auto_eng = 1'b1; fin_delay = 5;
    push_job(2'd0, 11'h010);
    push_job(2'd1, 11'h010);
    push_job(2'd2, 11'h010);
    H_int = 1'b1; E_int = 1'b1; D_int = 1'b1; index = 11'h010;
    tick();
    H_int = 1'b0; E_int = 1'b0; D_int = 1'b0;
    wait_done("t2_wait", base_d + 3, 100);
    check("t2_starts", start_cnt - base_s, 3);
    check("t2_ovf", ovf, 0);
    check("t2_queue_empty", exp_q.size() + exp_done_q.size(), 0);

    // test 3: overflow while the engine is stalled
    do_reset();
    base_d = done_cnt;
    auto_eng = 1'b1;
    push_job(2'd1, 11'h001);
    E_int = 1'b1; index = 11'h001;
    tick();
    E_int = 1'b0;
    tick();
    E_int = 1'b1; index = 11'h002;
    tick();
    E_int = 1'b0;
    check("t3_ovf", ovf, 3'b010);
    tick();
    eng_ready = 1'b1;
    wait_done("t3_wait", base_d + 1, 50);
    repeat (10) tick();
    check("t3_one_done", done_cnt - base_d, 1);
    check("t3_ovf_sticky", ovf, 3'b010);
    check("t3_busy", busy, 0);

    // test 4a: held level, four stalled cycles in ISSUE
    do_reset();
    base_s = start_cnt; base_d = done_cnt;
    auto_eng = 1'b1;
    push_job(2'd2, 11'h3ff);
    D_int = 1'b1; index = 11'h3ff;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_stall_no_start", eng_start, 0);
    end
    tick();
    eng_ready = 1'b1;
    #1;
    check("t4_start_on_ready", eng_start, 1);
    tick();
    tick();
    D_int = 1'b0;
    wait_done("t4_wait", base_d + 1, 50);
    repeat (10) tick();
    check("t4_one_start", start_cnt - base_s, 1);
    check("t4_one_done", done_cnt - base_d, 1);
    check("t4_ovf", ovf, 0);

    // test 4b: new request in the issue cycle replaces the outgoing one
    do_reset();
    base_s = start_cnt; base_d = done_cnt;
    auto_eng = 1'b1;
    push_job(2'd1, 11'h0aa);
    push_job(2'd1, 11'h0bb);
    E_int = 1'b1; index = 11'h0aa;
    tick();
    E_int = 1'b0;
    tick();
    tick();
    tick();
    E_int = 1'b1; index = 11'h0bb; eng_ready = 1'b1;
    #1;
    check("t4b_start", eng_start, 1);
    tick();
    E_int = 1'b0;
    wait_done("t4b_wait", base_d + 2, 100);
    check("t4b_starts", start_cnt - base_s, 2);
    check("t4b_ovf", ovf, 0);

    // test 5: reset while the job is in flight
    do_reset();
    base_d = done_cnt;
    eng_ready = 1'b1;
    exp_q.push_back({2'd0, 11'h077});
    H_int = 1'b1; index = 11'h077;
    tick();
    H_int = 1'b0;
    tick();
    check("t5_start", eng_start, 1);
    tick();
    rst = 1'b1; man_fin = 1'b1;
    tick();
    check("t5_outputs_zero", {H_done, E_done, D_done, eng_start, eng_op, eng_index}, 0);
    check("t5_busy", busy, 0);
    check("t5_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    man_fin = 1'b0;
    check("t5_no_done", {D_done, E_done, H_done}, 0);
    repeat (5) tick();
    check("t5_done_count", done_cnt - base_d, 0);
    check("t5_idle", busy, 0);

`ifdef ACCEL_TIMEOUT_EN
    // test 6: watchdog expiry
    do_reset();
    base_d = done_cnt;
    eng_ready = 1'b1;
    push_job(2'd0, 11'h123);
    H_int = 1'b1; index = 11'h123;
    tick();
    H_int = 1'b0;
    tick();
    check("t6_start", eng_start, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t6_no_early_done", H_done, 0);
    end
    tick();
    check("t6_h_done", H_done, 1);
    check("t6_timeout_err", timeout_err, 1);
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    repeat (4) tick();
    check("t6_late_finish_ignored", done_cnt - base_d, 1);
    check("t6_err_sticky", timeout_err, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    miscompares++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
